linear_cordic_vectoring_mode: RTL
=================================

# linear_cordic_vectoring_mode

16-stage pipelined linear CORDIC in vectoring mode: drives Y toward zero by shifted add/subtract of X and accumulates the quotient in Z, giving Z_O ≈ Z_i + Y_i / X_i. It is the inverse companion of the linear rotation-mode unit, which multiplies. The two share the Q1.14 format and the 16-stage structure, so they can be cascaded or swapped in the datapath. Throughput is one sample per clock, with a valid flag and a divide-domain error flag carried down the pipe.

## Interface
- No parameters. Fixed: width 16, 16 stages, `ONE_Q14` = 16384 (1.0 in Q1.14).
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; all pipeline state is cleared while it is low
- in_valid  input  1  X_i/Y_i/Z_i are valid this cycle
- X_i  input  16  signed Q1.14 divisor; must be > 0
- Y_i  input  16  signed Q1.14 dividend
- Z_i  input  16  signed Q1.14 accumulator seed
- out_valid  output  1  X_O/Y_O/Z_O/div_err hold a completed sample
- X_O  output  16  X passed through unchanged
- Y_O  output  16  residual Y, ≈ 0 on convergence
- Z_O  output  16  Z_i + Y_i/X_i, in Q1.14
- div_err  output  1  sample had X_i ≤ 0 (X_i[15] set or X_i == 0)

## Operation
- Stage k = 0..15 has registers X_k, Y_k, Z_k, v_k and e_k. Stage 0 takes the inputs; stage 15 drives the outputs.
- Per-stage update when the incoming valid is 1:
  - if Y_in[15] == 0: Y = Y_in − (X_in >>> k) and Z = Z_in + (ONE_Q14 >>> k)
  - else: Y = Y_in + (X_in >>> k) and Z = Z_in − (ONE_Q14 >>> k)
  - X = X_in
- All arithmetic is 16-bit two's complement. Wrap-around, no saturation. Shifts are arithmetic.
- At k = 15, ONE_Q14 >>> 15 = 0, so Z is unchanged in the last stage. Stage 15 is kept for latency symmetry with the rotation unit.
- Convergence domain: X_i > 0 and |Y_i/X_i| < ~1.9999. Results outside this domain are wrap values and carry no guarantee. No flag is raised for range overflow.
- Valid handling:
  - v_k <= v_(k−1), with v_(−1) = in_valid.
  - Data registers of stage k load only when v_(k−1) = 1 and otherwise hold their previous contents.
  - When out_valid = 0 the outputs therefore show the last valid result.
- Error flag:
  - e_0 <= in_valid & (X_i[15] | (X_i == 0)).
  - e_k <= e_(k−1), loaded under the same condition as the data registers.
  - The data path still computes normally when div_err is set. Z_O is meaningless for that sample.

## Timing
- Latency: 16 cycles. A sample presented with in_valid on edge n appears with out_valid = 1 after edge n+15, i.e. for one cycle following the 16th edge.
- Throughput: 1 sample/cycle. Back-to-back samples and bubbles are both legal. No backpressure.
- Reset: while reset = 0, every X/Y/Z register reads 0 and every v/e register reads 0, asynchronously. After reset:
  - X_O = Y_O = Z_O = 0
  - out_valid = 0, div_err = 0
- Reset mid-stream: all in-flight samples are discarded and none emerge after release. The first post-reset input has full 16-cycle latency.
- Reset deasserts synchronously to the design. Inputs sampled on the first edge with reset = 1 are accepted.
- The valid/error pipe is never gated by anything other than reset.

## Test plan
- Reset:
  - Stimulus: hold reset = 0 with random inputs and in_valid = 1, then release.
  - Required: X_O/Y_O/Z_O = 0 and out_valid = div_err = 0 throughout reset, and no out_valid for 16 cycles after release.
- Basic divide:
  - Stimulus: X_i = 8192, Y_i = 4096, Z_i = 0, single cycle.
  - Required: exactly 16 cycles later out_valid = 1 for one cycle, Z_O = 8192 ±4, |Y_O| ≤ 4, X_O = 8192, div_err = 0.
- Negative quotient with seed:
  - Stimulus: X_i = 16384, Y_i = −8192, Z_i = 4096.
  - Required: Z_O = −4096 ±4 and |Y_O| ≤ 4.
- Streaming and bubbles:
  - Stimulus: 40 random in-domain samples with in_valid toggling randomly.
  - Required: out_valid pattern equals the in_valid pattern delayed 16 cycles, each Z_O within ±4 LSB of the model Z_i + round(Y_i·16384/X_i), and outputs hold between valids.
- Error flag:
  - Stimulus: X_i = 0, then X_i = −16384, then X_i = 1.
  - Required: div_err = 1, 1, 0 on the corresponding out_valid cycles.
- Reset mid-operation:
  - Stimulus: 10 samples in flight, then reset = 0 for 1 cycle asynchronously, then released.
  - Required: out_valid drops immediately, none of the 10 samples ever emerge, and a new sample after release exits 16 cycles later with a correct value.

Source files
------------

// File: rtl/linear_cordic_vectoring_mode.sv
// 16-stage pipelined linear CORDIC, vectoring mode: Z_O = Z_i + Y_i / X_i.
// Q1.14 datapath, one sample per clock, valid and divide-error carried down the pipe.
module linear_cordic_vectoring_mode (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic signed [15:0] X_i,
    input  logic signed [15:0] Y_i,
    input  logic signed [15:0] Z_i,
    output logic               out_valid,
    output logic signed [15:0] X_O,
    output logic signed [15:0] Y_O,
    output logic signed [15:0] Z_O,
    output logic               div_err
);

    localparam int N = 16;
    localparam int W = 16;
    localparam logic signed [W-1:0] ONE_Q14 = 16'sd16384;

    logic signed [W-1:0] r_x [N];
    logic signed [W-1:0] r_y [N];
    logic signed [W-1:0] r_z [N];
    logic [N-1:0]        r_v;
    logic [N-1:0]        r_e;

    logic signed [W-1:0] w_xin [N];
    logic signed [W-1:0] w_yin [N];
    logic signed [W-1:0] w_zin [N];
    logic signed [W-1:0] w_xsh [N];
    logic signed [W-1:0] w_zsh [N];
    logic signed [W-1:0] w_ynx [N];
    logic signed [W-1:0] w_znx [N];
    logic [N-1:0]        w_vin;
    logic [N-1:0]        w_ein;
    logic                w_e0;

    assign w_e0  = in_valid & (X_i[W-1] | (X_i == '0));
    assign w_vin = {r_v[N-2:0], in_valid};
    assign w_ein = {r_e[N-2:0], w_e0};

    always_comb begin
        w_xin[0] = X_i;
        w_yin[0] = Y_i;
        w_zin[0] = Z_i;
        for (int k = 1; k < N; k++) begin
            w_xin[k] = r_x[k-1];
            w_yin[k] = r_y[k-1];
            w_zin[k] = r_z[k-1];
        end
        // Y sign picks the direction that pulls the residual toward zero
        for (int k = 0; k < N; k++) begin
            w_xsh[k] = w_xin[k] >>> k;
            w_zsh[k] = ONE_Q14 >>> k;
            if (w_yin[k][W-1]) begin
                w_ynx[k] = w_yin[k] + w_xsh[k];
                w_znx[k] = w_zin[k] - w_zsh[k];
            end else begin
                w_ynx[k] = w_yin[k] - w_xsh[k];
                w_znx[k] = w_zin[k] + w_zsh[k];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v <= '0;
            r_e <= '0;
            for (int k = 0; k < N; k++) begin
                r_x[k] <= '0;
                r_y[k] <= '0;
                r_z[k] <= '0;
            end
        end else begin
            r_v <= w_vin;
            for (int k = 0; k < N; k++) begin
                if (w_vin[k]) begin
                    r_x[k] <= w_xin[k];
                    r_y[k] <= w_ynx[k];
                    r_z[k] <= w_znx[k];
                    r_e[k] <= w_ein[k];
                end
            end
        end
    end

    assign out_valid = r_v[N-1];
    assign div_err   = r_e[N-1];
    assign X_O       = r_x[N-1];
    assign Y_O       = r_y[N-1];
    assign Z_O       = r_z[N-1];

endmodule
